// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing for the runtime-programmable truth-table neuron.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_IN_BITS  = 7;
  localparam int DEF_OUT_BITS = 2;
  localparam int DEPTH        = 1 << DEF_IN_BITS;

  function automatic int table_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: one write port, one enabled read port, registered read-first output.
// Read data only changes when re is high, so a stalled consumer sees a stable value.
module lut_table_ram
  import lut_neuron_pkg::*;
#(
  parameter int ADDR_W = DEF_IN_BITS,
  parameter int DATA_W = DEF_OUT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int NUM_ENTRIES = table_depth(ADDR_W);

  (* rom_style = "distributed" *) logic [DATA_W-1:0] mem [NUM_ENTRIES];

  // Contents are deliberately not reset; the owner sweeps them instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-edge write to raddr returns the old word because both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_neuron_rt.sv
// Runtime-programmable truth-table neuron: 2-stage valid/ready lookup, config port, self-clearing table.
// Result appears two edges after the input is presented; output holds while out_ready is low.
module lut_neuron_rt
  import lut_neuron_pkg::*;
#(
  parameter int                  IN_BITS     = DEF_IN_BITS,
  parameter int                  OUT_BITS    = DEF_OUT_BITS,
  parameter logic [OUT_BITS-1:0] DEFAULT_OUT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_clear,
  output logic                cfg_ready,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

  state_t               state;
  logic [IN_BITS-1:0]   sweep_cnt;
  logic                 s1_valid;
  logic [IN_BITS-1:0]   s1_addr;

  logic                 s2_load;
  logic                 s1_adv;
  logic                 accept;
  logic                 tbl_we;
  logic [IN_BITS-1:0]   tbl_waddr;
  logic [OUT_BITS-1:0]  tbl_wdata;
  logic                 tbl_re;

  assign s2_load   = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_load;
  assign in_ready  = !rst && (state == RUN) && s1_adv;
  assign cfg_ready = !rst && (state == RUN) && !cfg_clear;
  assign accept    = in_valid && in_ready;

  // The sweep owns the write port in CLEAR; cfg_ready already folds in clear priority.
  assign tbl_we    = !rst && ((state == CLEAR) || (cfg_we && cfg_ready));
  assign tbl_waddr = (state == CLEAR) ? sweep_cnt : cfg_addr;
  assign tbl_wdata = (state == CLEAR) ? DEFAULT_OUT : cfg_data;
  assign tbl_re    = s2_load && s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (cfg_clear) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_valid && !out_valid) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
          end
        end
        default: begin
          state     <= CLEAR;
          sweep_cnt <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_addr <= in_data;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
      end
    end
  end

  lut_table_ram #(
    .ADDR_W (IN_BITS),
    .DATA_W (OUT_BITS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .re    (tbl_re),
    .raddr (s1_addr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_lut_neuron_rt.sv
// Scoreboard bench for lut_neuron_rt: interface-level table model feeds an expected-result queue.
module tb_lut_neuron_rt;

  localparam int IB   = 7;
  localparam int OB   = 2;
  localparam int NENT = 1 << IB;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IB-1:0] cfg_addr;
  logic [OB-1:0] cfg_data;
  logic          cfg_clear;
  logic          cfg_ready;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [IB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_data;

  always #5 clk = ~clk;

  lut_neuron_rt #(
    .IN_BITS     (IB),
    .OUT_BITS    (OB),
    .DEFAULT_OUT (2'b00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_clear (cfg_clear),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out   = 0;
  logic [OB-1:0] model [NENT];
  logic [OB-1:0] exp_q [$];
  bit            saw_block = 1'b0;
  bit            hold_pend = 1'b0;
  logic [OB-1:0] hold_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Writes seen in cycle k reach lookups accepted in cycle k; earlier accepts read the old word.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
      for (int i = 0; i < NENT; i++) model[i] = '0;
    end else begin
      if (hold_pend) begin
        check("hold_vld", 32'(out_valid), 32'd1);
        check("hold_dat", 32'(out_data), 32'(hold_dat));
      end
      hold_pend = out_valid && !out_ready;
      hold_dat  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check("out_dat", 32'(out_data), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && !in_ready && !busy) saw_block = 1'b1;
      if (cfg_we && cfg_ready) model[cfg_addr] = cfg_data;
      if (in_valid && in_ready) exp_q.push_back(model[in_data]);
      if (cfg_clear && !busy) begin
        for (int i = 0; i < NENT; i++) model[i] = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [IB-1:0] a);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic wr(input logic [IB-1:0] a, input logic [OB-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    check("wr_rdy", 32'(cfg_ready), 32'd1);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_q", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    cfg_clear = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset held for two edges, then the 128-entry sweep.
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    count_sweep(n);
    check("sweep_len", 32'(n), 32'd128);
    check("busy_fall", 32'(busy), 32'd0);

    // First lookup latency.
    tick();
    send(7'b0000000);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat2_vld", 32'(out_valid), 32'd1);
    check("lat2_dat", 32'(out_data), 32'd0);

    // Program and stream.
    tick();
    wr(7'b1000000, 2'b11);
    wr(7'b0010000, 2'b01);
    send(7'b1000000);
    send(7'b0010000);
    send(7'b0000001);
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_b_vld", 32'(out_valid), 32'd1);
    check("stream_b_dat", 32'(out_data), 32'd1);
    @(negedge clk);
    check("stream_c_vld", 32'(out_valid), 32'd1);
    check("stream_c_dat", 32'(out_data), 32'd0);
    @(negedge clk);
    check("stream_end_vld", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low three cycles mid-stream.
    tick();
    base      = n_out;
    saw_block = 1'b0;
    fork
      begin
        send(7'b1000000);
        send(7'b0010000);
        send(7'b0000001);
        send(7'd5);
        in_valid = 1'b0;
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(n_out - base), 32'd4);
    check("bp_block", 32'(saw_block), 32'd1);

    // Read/write collision on address 5.
    tick();
    in_valid = 1'b1;
    in_data  = 7'd5;
    @(negedge clk);
    check("col_acc1", 32'(in_ready), 32'd1);
    tick();
    cfg_we   = 1'b1;
    cfg_addr = 7'd5;
    cfg_data = 2'b10;
    @(negedge clk);
    check("col_acc2", 32'(in_ready), 32'd1);
    check("col_cfg_rdy", 32'(cfg_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    @(negedge clk);
    check("col_old_vld", 32'(out_valid), 32'd1);
    check("col_old_dat", 32'(out_data), 32'd0);
    @(negedge clk);
    check("col_new_dat", 32'(out_data), 32'd2);
    drain();

    // Clear with two results in flight and a competing write.
    tick();
    wr(7'd3, 2'b11);
    out_ready = 1'b0;
    send(7'b1000000);
    send(7'b0010000);
    in_valid  = 1'b0;
    cfg_clear = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 7'd3;
    cfg_data  = 2'b01;
    out_ready = 1'b1;
    @(negedge clk);
    check("clr_cfg_rdy", 32'(cfg_ready), 32'd0);
    tick();
    cfg_clear = 1'b0;
    cfg_we    = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("clr_busy_long", 32'(n >= 129), 32'd1);
    check("clr_busy_fell", 32'(busy), 32'd0);
    check("clr_inflight", 32'(exp_q.size()), 32'd0);
    tick();
    send(7'd3);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clr_lu3_vld", 32'(out_valid), 32'd1);
    check("clr_lu3_dat", 32'(out_data), 32'd0);
    drain();

    // Reset mid-stream, then again mid-sweep at counter 40.
    tick();
    out_ready = 1'b0;
    send(7'b1000000);
    send(7'b0010000);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ms_vld", 32'(out_valid), 32'd0);
    check("rst_ms_busy", 32'(busy), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    count_sweep(n);
    check("sweep_restart_len", 32'(n), 32'd128);
    tick();
    send(7'b1000000);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
